fifo_sync_simd: RTL and testbench
=================================

Name: fifo_sync_simd

Overview:
- Single-clock synchronous FIFO, parametrised in depth, lane width (bw) and SIMD lane count.
- Successor to the fixed depth-8 FIFO read path: generalises depth to any power of two and adds full/empty flags, sticky overflow/underflow error flags, synchronous flush and optional occupancy reporting.
- Sits between the L0/IFIFO/OFIFO producers and consumers in the SIMD core; one entry = one SIMD word (simd*bw bits).

Parameters:
- bw, 4, bits per SIMD lane.
- simd, 1, lanes per entry; entry width W = simd*bw.
- depth, 16, entries; power of two, >= 2.
- addr_bw, 4, log2(depth); must equal log2(depth), checked at elaboration.
- af_level, 12, almost-full threshold in entries (used only with FIFO_OCCUPANCY_EN).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in  input  W  write data.
- wr  input  1  write request.
- rd  input  1  read request; pops the word currently on out.
- flush  input  1  synchronous clear of pointers.
- err_clr  input  1  synchronous clear of sticky error flags.
- out  output  W  head-of-FIFO data (first-word fall-through).
- o_full  output  1  FIFO holds depth entries.
- o_empty  output  1  FIFO holds 0 entries.
- o_overflow  output  1  sticky: a write was rejected.
- o_underflow  output  1  sticky: a read was rejected.
- o_count  output  addr_bw+1  occupancy (FIFO_OCCUPANCY_EN only).
- o_almost_full  output  1  count >= af_level (FIFO_OCCUPANCY_EN only).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: wr_ptr = rd_ptr = 0, o_empty = 1, o_full = 0, o_overflow = 0, o_underflow = 0, out = 0, o_count = 0, o_almost_full = 0. Storage array is not reset.
- Reset asserted mid-operation: all contents are discarded immediately, without waiting for a clock edge.
- Pointers: wr_ptr and rd_ptr are addr_bw+1 bits; the MSB is the wrap bit, and the low addr_bw bits index storage.
  - o_empty = (wr_ptr == rd_ptr).
  - o_full = (low bits equal) and (wrap bits differ).
  - Both flags are combinational from registered pointers.
- Read accept: rd_acc = rd & !o_empty.
- Write accept: wr_acc = wr & (!o_full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- On the rising edge:
  - wr_acc writes in to mem[wr_ptr low bits] and increments wr_ptr.
  - rd_acc increments rd_ptr.
  - Pointers wrap naturally modulo 2*depth.
- Read latency / output:
  - out = mem[rd_ptr low bits] combinationally, via a log2(depth)-level 2:1 mux tree.
  - Data written in cycle N appears on out after edge N if the FIFO was empty.
  - out is forced to 0 while o_empty = 1.
- Simultaneous rd and wr:
  - Empty: the write is accepted, the read is rejected, and underflow is flagged.
  - Full: both are accepted and occupancy is unchanged.
  - Otherwise: both are accepted.
- Error flags:
  - o_overflow sets on an edge with wr & !wr_acc.
  - o_underflow sets on an edge with rd & !rd_acc.
  - Both hold until reset or err_clr.
  - err_clr has priority over a same-cycle set (clear wins).
- flush:
  - On the edge, wr_ptr and rd_ptr go to 0; rd and wr that cycle are ignored.
  - Error flags are not changed by flush, and no errors are flagged in a flush cycle.
- Rejected operations never move pointers or modify storage.

Optional Feature:
- Macro: FIFO_OCCUPANCY_EN.
- Defined:
  - o_count = wr_ptr - rd_ptr (addr_bw+1 bits, range 0..depth).
  - o_almost_full = (o_count >= af_level).
  - Both are combinational from the pointers and are 0 in reset.
- Not defined: o_count and o_almost_full ports are absent, and no subtractor is synthesised.

Test Plan:
- Fill/drain, depth = 16, simd = 2, bw = 4: write 0x01..0x10 (16 writes) → o_full = 1 after the 16th edge, o_empty = 0. Read 16 → out sequence 0x01..0x10, o_empty = 1, out = 0.
- Overflow: full FIFO, assert wr alone with in = 0xAA → pointers unchanged, o_overflow = 1 and held; next read returns the oldest word. err_clr for one cycle → o_overflow = 0.
- Underflow and simultaneous ops on empty: empty FIFO, rd & wr with in = 0x5C → o_empty = 0, out = 0x5C, o_underflow = 1. Then, on a full FIFO, rd & wr with in = 0x33 → o_full stays 1, the popped word is the oldest, and 0x33 is popped last.
- Wrap-around: repeat 40 cycles of write 1 / read 1 with the FIFO holding 3 entries → data order preserved across pointer wrap; o_full and o_empty never assert.
- Flush / async reset: 7 entries, pulse flush with rd = wr = 1 → o_empty = 1 next cycle, errors unchanged. Refill 5 entries, assert reset between clock edges → o_empty = 1 and out = 0 immediately, before the next edge.
- FIFO_OCCUPANCY_EN, af_level = 12: write 12 entries → o_count = 12, o_almost_full = 1. Read 1 → o_count = 11, o_almost_full = 0. Build without the macro → compiles with no o_count or o_almost_full ports.

Source files
------------

// File: rtl/fifo_sync_simd.sv
// Single-clock FIFO of SIMD words with flags, sticky errors and flush.
// Define FIFO_OCCUPANCY_EN to add o_count and o_almost_full ports.
module fifo_sync_simd #(
    parameter int bw       = 4,
    parameter int simd     = 1,
    parameter int depth    = 16,
    parameter int addr_bw  = 4,
    parameter int af_level = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [simd*bw-1:0]   in,
    input  logic                 wr,
    input  logic                 rd,
    input  logic                 flush,
    input  logic                 err_clr,
    output logic [simd*bw-1:0]   out,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_overflow,
    output logic                 o_underflow
`ifdef FIFO_OCCUPANCY_EN
    ,
    output logic [addr_bw:0]     o_count,
    output logic                 o_almost_full
`endif
);

    localparam int W = simd * bw;
    localparam logic [addr_bw:0] PTR_ONE = 1;

    if (addr_bw != $clog2(depth)) begin : g_bad_addr_bw
        $error("fifo_sync_simd: addr_bw must equal log2(depth)");
    end
    if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_simd: depth must be a power of two >= 2");
    end

    logic [W-1:0]       r_mem [depth];
    logic [addr_bw:0]   r_wr_ptr;
    logic [addr_bw:0]   r_rd_ptr;
    logic               r_overflow;
    logic               r_underflow;

    logic [addr_bw-1:0] w_wr_addr;
    logic [addr_bw-1:0] w_rd_addr;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_ovf_set;
    logic               w_udf_set;
    logic [W-1:0]       w_lvl [depth];

    assign w_wr_addr = r_wr_ptr[addr_bw-1:0];
    assign w_rd_addr = r_rd_ptr[addr_bw-1:0];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (w_wr_addr == w_rd_addr)
                   && (r_wr_ptr[addr_bw] != r_rd_ptr[addr_bw]);

    // A flush cycle swallows both requests, so nothing is accepted or flagged.
    assign w_rd_acc  = rd && !o_empty && !flush;
    assign w_wr_acc  = wr && (!o_full || w_rd_acc) && !flush;
    assign w_ovf_set = wr && !w_wr_acc && !flush;
    assign w_udf_set = rd && !w_rd_acc && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (err_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) r_overflow  <= 1'b1;
            if (w_udf_set) r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[w_wr_addr] <= in;
    end

    // Binary 2:1 mux tree, LSB selects at the leaves, reduced in place.
    always_comb begin
        w_lvl = r_mem;
        for (int l = addr_bw - 1; l >= 0; l--) begin
            for (int k = 0; k < (1 << l); k++) begin
                w_lvl[k] = w_rd_addr[addr_bw-1-l] ? w_lvl[2*k+1]
                                                  : w_lvl[2*k];
            end
        end
    end

    assign out         = o_empty ? '0 : w_lvl[0];
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

`ifdef FIFO_OCCUPANCY_EN
    localparam logic [addr_bw:0] AF_LEVEL = af_level[addr_bw:0];
    assign o_count       = r_wr_ptr - r_rd_ptr;
    assign o_almost_full = (o_count >= AF_LEVEL);
`endif

endmodule

// File: tb/tb_fifo_sync_simd.sv
// Directed scoreboard bench for fifo_sync_simd (depth 16, simd 2, bw 4).
module tb_fifo_sync_simd;

    localparam int DEPTH = 16;
    localparam int W     = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in;
    logic         wr, rd, flush, err_clr;
    logic [W-1:0] out;
    logic         o_full, o_empty, o_overflow, o_underflow;
`ifdef FIFO_OCCUPANCY_EN
    logic [4:0]   o_count;
    logic         o_almost_full;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q [$];
    logic [W-1:0] last_pop;
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;

    fifo_sync_simd #(
        .bw(4), .simd(2), .depth(DEPTH), .addr_bw(4), .af_level(12)
    ) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
        .flush(flush), .err_clr(err_clr), .out(out),
        .o_full(o_full), .o_empty(o_empty),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
`ifdef FIFO_OCCUPANCY_EN
        , .o_count(o_count), .o_almost_full(o_almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        logic [W-1:0] exp_out;
        exp_out = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".out"}, 32'(out), 32'(exp_out));
        chk({tag, ".full"}, 32'(o_full), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(o_empty), 32'(q.size() == 0));
        chk({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(o_underflow), 32'(m_udf));
    endtask

    // One clock: drive, let the edge pass, update the model, compare.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [W-1:0] d, input logic f,
                        input logic ec);
        bit ra, wa;
        wr = w; rd = r; in = d; flush = f; err_clr = ec;
        ra = r && !f && (q.size() > 0);
        wa = w && !f && ((q.size() < DEPTH) || ra);
        @(posedge clk);
        #1;
        if (ec) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && !f && !wa) m_ovf = 1'b1;
            if (r && !f && !ra) m_udf = 1'b1;
        end
        if (f) q.delete();
        else begin
            if (ra) last_pop = q.pop_front();
            if (wa) q.push_back(d);
        end
        wr = 0; rd = 0; flush = 0; err_clr = 0;
        chk_state(tag);
    endtask

    initial begin
        reset = 1'b1;
        in = '0; wr = 0; rd = 0; flush = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 1; i <= DEPTH; i++) step("fill", 1, 0, W'(i), 0, 0);
        chk("fill.full_end", 32'(o_full), 32'd1);

        step("ovf_wr", 1, 0, 8'hAA, 0, 0);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        step("ovf_hold", 0, 0, 8'h00, 0, 0);
        step("ovf_pop", 0, 1, 8'h00, 0, 0);
        chk("ovf_oldest", 32'(last_pop), 32'h01);
        step("ovf_refill", 1, 0, 8'h11, 0, 0);
        step("ovf_clr", 0, 0, 8'h00, 0, 1);
        chk("ovf_cleared", 32'(o_overflow), 32'd0);

        for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 8'h00, 0, 0);
        chk("drain.out0", 32'(out), 32'd0);

        step("udf_rw", 1, 1, 8'h5C, 0, 0);
        chk("udf_out", 32'(out), 32'h5C);
        chk("udf_flag", 32'(o_underflow), 32'd1);

        for (int i = 0; i < DEPTH - 1; i++)
            step("fill2", 1, 0, W'(8'h60 + i), 0, 0);
        step("full_rw", 1, 1, 8'h33, 0, 0);
        chk("full_rw.pop", 32'(last_pop), 32'h5C);
        chk("full_rw.full", 32'(o_full), 32'd1);
        for (int i = 0; i < DEPTH; i++) step("drain2", 0, 1, 8'h00, 0, 0);
        chk("last_is_33", 32'(last_pop), 32'h33);

        step("clr2", 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) step("wrap_pre", 1, 0, W'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 40; i++)
            step("wrap", 1, 1, W'($urandom_range(255)), 0, 0);
        for (int i = 0; i < 3; i++) step("wrap_drain", 0, 1, 8'h00, 0, 0);

        step("udf_set", 0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) step("pre_flush", 1, 0, W'(8'h70 + i), 0, 0);
        step("flush", 1, 1, 8'hEE, 1, 0);
        chk("flush.empty", 32'(o_empty), 32'd1);
        chk("flush.udf_kept", 32'(o_underflow), 32'd1);

        for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, W'(8'h90 + i), 0, 0);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        chk("async_rst.empty", 32'(o_empty), 32'd1);
        chk("async_rst.out", 32'(out), 32'd0);
        chk_state("async_rst");
        @(negedge clk);
        reset = 1'b0;

`ifdef FIFO_OCCUPANCY_EN
        chk("occ.reset", 32'(o_count), 32'd0);
        for (int i = 0; i < 12; i++) step("occ_fill", 1, 0, W'(i), 0, 0);
        chk("occ.count12", 32'(o_count), 32'd12);
        chk("occ.af1", 32'(o_almost_full), 32'd1);
        step("occ_rd", 0, 1, 8'h00, 0, 0);
        chk("occ.count11", 32'(o_count), 32'd11);
        chk("occ.af0", 32'(o_almost_full), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
